// File: rtl/state_sequencer_pkg.sv
// Purpose: shared types and constants for the state sequencer slice.
// Latency: n/a (types only).
// Backpressure: n/a.
package seq_pkg;

  // Step pattern applied on each prescaler strobe.
  typedef enum logic [1:0] {
    MODE_UP       = 2'd0,
    MODE_DOWN     = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_ONESHOT  = 2'd3
  } mode_t;

  // Ping-pong travel direction.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/state_sequencer_if.sv
// Purpose: control/status bundle between a controller and the state sequencer.
// Latency: n/a (wires only).
// Backpressure: none; en is the only stall control.
interface state_sequencer_if #(
  parameter int SW = 2
);
  import seq_pkg::*;

  logic          en;
  mode_t         mode;
  logic          start;
  logic          load;
  logic [SW-1:0] load_val;
  logic [SW-1:0] state;
  logic          tick;
  logic          wrap;
  logic          done;

  modport master (
    output en, mode, start, load, load_val,
    input  state, tick, wrap, done
  );

  modport slave (
    input  en, mode, start, load, load_val,
    output state, tick, wrap, done
  );

endinterface

// File: rtl/tick_prescaler.sv
// Purpose: clock-enable prescaler, one ce strobe every DIV enabled cycles.
// Latency: ce is combinational from the count register; clr takes effect next edge.
// Backpressure: en low freezes the count; no ce while frozen.
module tick_prescaler #(
  parameter int DIV = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic ce
);

  // DIV=1 would give a zero-width counter; keep one bit that never moves.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign ce = en && (count == LAST);

  // Count 0..DIV-1 while enabled; clear restarts the period from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= ce ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/state_sequencer.sv
// Purpose: steps a state index through N_STATES states in one of four patterns.
// Latency: state/tick/wrap/done registered, visible the cycle after the strobe edge.
// Backpressure: none; en low freezes prescaler and state, load/start always act.
module state_sequencer
  import seq_pkg::*;
#(
  parameter int N_STATES = 4,
  parameter int DIV      = 100,
  parameter int SW       = $clog2(N_STATES)
) (
  input  logic             clk,
  input  logic             rst_n,
  state_sequencer_if.slave bus
);

  localparam logic [SW-1:0] LAST = SW'(N_STATES - 1);

  logic          step_ce;
  logic          clr;
  logic [SW-1:0] state_q;
  logic          dir_q;
  logic          done_q;
  logic          tick_q;
  logic          wrap_q;

  logic [SW-1:0] up_val;
  logic [SW-1:0] dn_val;
  logic [SW-1:0] nxt_state;
  logic          nxt_dir;
  logic          nxt_done;
  logic          nxt_move;
  logic          nxt_wrap;

  // Either strobe restarts the step period.
  assign clr = bus.load | bus.start;

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .clr   (clr),
    .ce    (step_ce)
  );

  assign up_val = state_q + SW'(1);
  assign dn_val = state_q - SW'(1);

  // Next-step candidate for the current mode; only committed on step_ce.
  always_comb begin
    nxt_state = state_q;
    nxt_dir   = dir_q;
    nxt_done  = done_q;
    nxt_move  = 1'b0;
    nxt_wrap  = 1'b0;
    case (bus.mode)
      MODE_UP: begin
        nxt_move = 1'b1;
        if (state_q == LAST) begin
          nxt_state = '0;
          nxt_wrap  = 1'b1;
        end else begin
          nxt_state = up_val;
        end
      end
      MODE_DOWN: begin
        nxt_move = 1'b1;
        if (state_q == '0) begin
          nxt_state = LAST;
          nxt_wrap  = 1'b1;
        end else begin
          nxt_state = dn_val;
        end
      end
      MODE_PINGPONG: begin
        nxt_move = 1'b1;
        if (dir_q == DIR_UP) begin
          if (state_q == LAST) begin
            // Parked on the top (load or mode switch): turn around quietly.
            nxt_state = dn_val;
            nxt_dir   = DIR_DOWN;
          end else begin
            nxt_state = up_val;
            if (up_val == LAST) begin
              nxt_dir  = DIR_DOWN;
              nxt_wrap = 1'b1;
            end
          end
        end else begin
          if (state_q == '0) begin
            // Parked on the bottom: turn around quietly.
            nxt_state = up_val;
            nxt_dir   = DIR_UP;
          end else begin
            nxt_state = dn_val;
            if (dn_val == '0) begin
              nxt_dir  = DIR_UP;
              nxt_wrap = 1'b1;
            end
          end
        end
      end
      MODE_ONESHOT: begin
        // Terminal state absorbs further strobes without a tick.
        if (!done_q && state_q != LAST) begin
          nxt_move  = 1'b1;
          nxt_state = up_val;
          if (up_val == LAST) begin
            nxt_done = 1'b1;
            nxt_wrap = 1'b1;
          end
        end
      end
      default: begin
        nxt_move = 1'b0;
      end
    endcase
  end

  // State, direction, done and pulse registers; load beats start beats step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      dir_q   <= DIR_UP;
      done_q  <= 1'b0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (bus.load) begin
      state_q <= (bus.load_val > LAST) ? LAST : bus.load_val;
      dir_q   <= DIR_UP;
      done_q  <= 1'b0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (bus.start) begin
      state_q <= '0;
      dir_q   <= DIR_UP;
      done_q  <= 1'b0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (step_ce) begin
      state_q <= nxt_state;
      dir_q   <= nxt_dir;
      done_q  <= nxt_done;
      tick_q  <= nxt_move;
      wrap_q  <= nxt_wrap;
    end else begin
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end
  end

  assign bus.state = state_q;
  assign bus.tick  = tick_q;
  assign bus.wrap  = wrap_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_state_sequencer.sv
// Purpose: directed, table-driven checks of the state sequencer across several configurations.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: n/a.
module tb_state_sequencer;
  import seq_pkg::*;

  logic clk;
  logic rst_n;

  int n_chk  = 0;
  int n_fail = 0;

  // u0: defaults, u1: N=5 DIV=1, u2: N=4 DIV=3, u3: N=6 DIV=2, u4: N=4 DIV=10
  state_sequencer_if #(.SW(2)) if0 ();
  state_sequencer_if #(.SW(3)) if1 ();
  state_sequencer_if #(.SW(2)) if2 ();
  state_sequencer_if #(.SW(3)) if3 ();
  state_sequencer_if #(.SW(2)) if4 ();

  state_sequencer #(.N_STATES(4), .DIV(100)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  state_sequencer #(.N_STATES(5), .DIV(1))   u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  state_sequencer #(.N_STATES(4), .DIV(3))   u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  state_sequencer #(.N_STATES(6), .DIV(2))   u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
  state_sequencer #(.N_STATES(4), .DIV(10))  u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    mode_t      mode;
    logic       start;
    logic       load;
    logic [2:0] load_val;
    logic [2:0] st;
    logic       tk;
    logic       wr;
    logic       dn;
  } vec_t;

  vec_t vt[25];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string nm, input int st, input int tk, input int wr, input int dn,
                         input int est, input int etk, input int ewr, input int edn);
    chk({nm, "_state"}, st, est);
    chk({nm, "_tick"},  tk, etk);
    chk({nm, "_wrap"},  wr, ewr);
    chk({nm, "_done"},  dn, edn);
  endtask

  initial begin
    int ticks;
    int wraps;
    int bad;

    // Ping-pong 0..4..0..1, then load/start/mode coverage on u1 (N=5, DIV=1).
    vt[0]  = '{1'b1, MODE_PINGPONG, 1'b0, 1'b0, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0};
    vt[1]  = '{1'b1, MODE_PINGPONG, 1'b0, 1'b0, 3'd0, 3'd2, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{1'b1, MODE_PINGPONG, 1'b0, 1'b0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{1'b1, MODE_PINGPONG, 1'b0, 1'b0, 3'd0, 3'd4, 1'b1, 1'b1, 1'b0};
    vt[4]  = '{1'b1, MODE_PINGPONG, 1'b0, 1'b0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{1'b1, MODE_PINGPONG, 1'b0, 1'b0, 3'd0, 3'd2, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{1'b1, MODE_PINGPONG, 1'b0, 1'b0, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{1'b1, MODE_PINGPONG, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0};
    vt[8]  = '{1'b1, MODE_PINGPONG, 1'b0, 1'b0, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{1'b0, MODE_PINGPONG, 1'b0, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b0, MODE_PINGPONG, 1'b0, 1'b1, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b1, MODE_UP,       1'b0, 1'b0, 3'd0, 3'd4, 1'b1, 1'b0, 1'b0};
    vt[12] = '{1'b1, MODE_UP,       1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0};
    vt[13] = '{1'b1, MODE_DOWN,     1'b0, 1'b0, 3'd0, 3'd4, 1'b1, 1'b1, 1'b0};
    vt[14] = '{1'b1, MODE_DOWN,     1'b0, 1'b0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0};
    vt[15] = '{1'b1, MODE_DOWN,     1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0};
    vt[16] = '{1'b1, MODE_ONESHOT,  1'b0, 1'b0, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0};
    vt[17] = '{1'b1, MODE_ONESHOT,  1'b0, 1'b0, 3'd0, 3'd2, 1'b1, 1'b0, 1'b0};
    vt[18] = '{1'b1, MODE_ONESHOT,  1'b0, 1'b0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0};
    vt[19] = '{1'b1, MODE_ONESHOT,  1'b0, 1'b0, 3'd0, 3'd4, 1'b1, 1'b1, 1'b1};
    vt[20] = '{1'b1, MODE_ONESHOT,  1'b0, 1'b0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b1};
    vt[21] = '{1'b1, MODE_ONESHOT,  1'b0, 1'b1, 3'd7, 3'd4, 1'b0, 1'b0, 1'b0};
    vt[22] = '{1'b1, MODE_DOWN,     1'b0, 1'b0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0};
    vt[23] = '{1'b1, MODE_PINGPONG, 1'b1, 1'b1, 3'd2, 3'd2, 1'b0, 1'b0, 1'b0};
    vt[24] = '{1'b1, MODE_PINGPONG, 1'b0, 1'b0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0};

    // ---------------- reset ----------------
    rst_n = 1'b0;
    if0.en = 1'b0; if0.mode = MODE_UP; if0.start = 1'b0; if0.load = 1'b0; if0.load_val = '0;
    if1.en = 1'b0; if1.mode = MODE_UP; if1.start = 1'b0; if1.load = 1'b0; if1.load_val = '0;
    if2.en = 1'b0; if2.mode = MODE_UP; if2.start = 1'b0; if2.load = 1'b0; if2.load_val = '0;
    if3.en = 1'b0; if3.mode = MODE_UP; if3.start = 1'b0; if3.load = 1'b0; if3.load_val = '0;
    if4.en = 1'b0; if4.mode = MODE_UP; if4.start = 1'b0; if4.load = 1'b0; if4.load_val = '0;
    #23;
    rst_n = 1'b1;
    chk_out("rst_u0", if0.state, if0.tick, if0.wrap, if0.done, 0, 0, 0, 0);
    chk_out("rst_u1", if1.state, if1.tick, if1.wrap, if1.done, 0, 0, 0, 0);

    // ---------------- free-run, defaults ----------------
    if0.en = 1'b1;
    ticks = 0;
    wraps = 0;
    for (int i = 1; i <= 400; i++) begin
      cyc();
      if (i == 99) chk("free_pre_step_state", if0.state, 0);
      if (if0.wrap) begin
        wraps++;
        chk("free_wrap_cycle", i, 400);
      end
      if (if0.tick) begin
        ticks++;
        chk("free_step_cycle", i, ticks * 100);
        chk("free_state", if0.state, ticks % 4);
      end
    end
    chk("free_tick_count", ticks, 4);
    chk("free_wrap_count", wraps, 1);
    if0.en = 1'b0;

    // ---------------- table vectors on u1 ----------------
    for (int v = 0; v < 25; v++) begin
      if1.en       = vt[v].en;
      if1.mode     = vt[v].mode;
      if1.start    = vt[v].start;
      if1.load     = vt[v].load;
      if1.load_val = vt[v].load_val;
      cyc();
      chk_out($sformatf("vec%0d", v), if1.state, if1.tick, if1.wrap, if1.done,
              vt[v].st, vt[v].tk, vt[v].wr, vt[v].dn);
    end
    if1.en = 1'b0; if1.start = 1'b0; if1.load = 1'b0;

    // ---------------- one-shot, N=4 DIV=3 ----------------
    if2.en = 1'b1;
    if2.mode = MODE_ONESHOT;
    for (int i = 1; i <= 9; i++) begin
      cyc();
      chk("os_state", if2.state, i / 3);
      if (i == 8) chk("os_done_early", if2.done, 0);
    end
    chk_out("os_final", if2.state, if2.tick, if2.wrap, if2.done, 3, 1, 1, 1);
    ticks = 0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (if2.tick) ticks++;
      if (if2.state != 2'd3 || !if2.done) bad++;
    end
    chk("os_hold_ticks", ticks, 0);
    chk("os_hold_bad", bad, 0);
    if2.start = 1'b1;
    cyc();
    if2.start = 1'b0;
    chk_out("os_start", if2.state, if2.tick, if2.wrap, if2.done, 0, 0, 0, 0);
    cyc();
    cyc();
    chk("os_resume_wait", if2.state, 0);
    cyc();
    chk("os_resume_state", if2.state, 1);
    chk("os_resume_tick", if2.tick, 1);
    if2.en = 1'b0;

    // ---------------- load / priority, N=6 DIV=2 ----------------
    if3.en = 1'b1;
    if3.mode = MODE_UP;
    if3.load = 1'b1;
    if3.load_val = 3'd7;
    cyc();
    if3.load = 1'b0;
    chk("ld_clamp_state", if3.state, 5);
    chk("ld_clamp_tick", if3.tick, 0);
    cyc();
    chk("ld_wait_state", if3.state, 5);
    cyc();
    chk_out("ld_wrap", if3.state, if3.tick, if3.wrap, if3.done, 0, 1, 1, 0);
    cyc();
    chk("ld_mid_state", if3.state, 0);
    // next edge carries step_ce; load and start both present
    if3.load = 1'b1;
    if3.start = 1'b1;
    if3.load_val = 3'd2;
    cyc();
    if3.load = 1'b0;
    if3.start = 1'b0;
    chk("ld_prio_state", if3.state, 2);
    chk("ld_prio_tick", if3.tick, 0);
    cyc();
    chk("ld_after1_state", if3.state, 2);
    chk("ld_after1_tick", if3.tick, 0);
    cyc();
    chk("ld_after2_state", if3.state, 3);
    chk("ld_after2_tick", if3.tick, 1);
    if3.en = 1'b0;

    // ---------------- enable gating, N=4 DIV=10 ----------------
    if4.en = 1'b1;
    if4.mode = MODE_UP;
    repeat (6) cyc();
    if4.en = 1'b0;
    ticks = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (if4.tick) ticks++;
      if (if4.state != 2'd0) bad++;
    end
    chk("en_gap_ticks", ticks, 0);
    chk("en_gap_state", bad, 0);
    if4.en = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("en_3rd_state", if4.state, 0);
    chk("en_3rd_tick", if4.tick, 0);
    cyc();
    chk("en_4th_state", if4.state, 1);
    chk("en_4th_tick", if4.tick, 1);
    if4.en = 1'b0;

    // ---------------- async reset mid-cycle, u1 ping-pong ----------------
    if1.en = 1'b1;
    if1.mode = MODE_PINGPONG;
    if1.start = 1'b1;
    cyc();
    if1.start = 1'b0;
    chk("ar_start_state", if1.state, 0);
    repeat (6) cyc();
    chk("ar_pre_state", if1.state, 2);
    chk("ar_pre_tick", if1.tick, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("ar_async", if1.state, if1.tick, if1.wrap, if1.done, 0, 0, 0, 0);
    #2;
    rst_n = 1'b1;
    cyc();
    chk_out("ar_first", if1.state, if1.tick, if1.wrap, if1.done, 1, 1, 0, 0);
    cyc();
    chk("ar_second_state", if1.state, 2);
    if1.en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/state_sequencer.md
# state_sequencer

Parametrised successor to the fixed 4-state, 1 Hz cyclic state machine. It advances a state index through `N_STATES` states at a programmable rate. The rate comes from an internal clock-enable prescaler rather than a derived clock. Supported step patterns are wrap-up, wrap-down, ping-pong and one-shot, with synchronous load/restart and step/wrap/done status pulses. It sits between the board clock and any downstream decoder (LEDs, display mux, stepper phases) that consumes a slow state index.

## Interface
- `N_STATES`, default 4: number of states. Must be ≥ 2.
- `DIV`, default 100: `clk` cycles per step. Must be ≥ 1; `DIV=1` steps every enabled cycle.
- `SW`, default `$clog2(N_STATES)`: state index width. Derived; not overridden.
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  global enable. Low freezes the prescaler and the state.
- `mode`  in  2  step pattern: 0 wrap-up, 1 wrap-down, 2 ping-pong, 3 one-shot.
- `start`  in  1  synchronous restart pulse.
- `load`  in  1  synchronous load strobe.
- `load_val`  in  SW  value loaded when `load` is high.
- `state`  out  SW  current state index.
- `tick`  out  1  one-cycle pulse in the first cycle a new state is visible.
- `wrap`  out  1  one-cycle pulse coincident with `tick` on wrap or ping-pong turnaround.
- `done`  out  1  one-shot terminal flag, level.

## Operation
- Reset (async assert, sync-released use): `state=0`, `tick=0`, `wrap=0`, `done=0`, prescaler count = 0, direction = up.
- Prescaler: the count runs 0..DIV-1 while `en=1`. `step_ce` = `en && count==DIV-1`; the count returns to 0 on that cycle.
- Priority per cycle: `load` > `start` > `step_ce`.
  - `load`: `state <= min(load_val, N_STATES-1)`; prescaler cleared; direction = up; `done` cleared; no `tick`/`wrap`.
  - `start`: `state <= 0`; prescaler cleared; direction = up; `done` cleared; no `tick`/`wrap`.
  - `load` and `start` act regardless of `en`.
- Step rules on `step_ce`:
  - Mode 0 (wrap-up): `N-1 -> 0` asserts `wrap`; otherwise `+1`.
  - Mode 1 (wrap-down): `0 -> N-1` asserts `wrap`; otherwise `-1`.
  - Mode 2 (ping-pong): moves in the current direction. On reaching `N-1` while going up, the direction flips to down. On reaching `0` while going down, it flips to up. `wrap` pulses on the step that lands on the endpoint. The sequence for N=4 is 0,1,2,3,2,1,0,1…
  - Mode 3 (one-shot): `+1` until `N-1`. The step landing on `N-1` sets `done` and pulses `wrap`. Further `step_ce` has no effect on `state`, and no `tick` is issued, until `start` or `load`.
- `tick` pulses on every `step_ce` that changes `state`.
- `mode` may change at any time; the new mode applies at the next `step_ce`. The direction register is retained, so ping-pong resumes in its last direction.
- An out-of-range `state` is unreachable. `load` clamps, and the step logic never exceeds `N-1`.

## Timing
- Step latency: `state`, `tick` and `wrap` update on the clock edge where `step_ce` is true. They are registered outputs, visible the following cycle.
- Step period is exactly `DIV` enabled cycles. Cycles with `en=0` do not count.
- First step after reset/start/load occurs `DIV` enabled cycles after the strobe cycle.
- `load`/`start` take effect on the next edge. A `load` coincident with `step_ce` suppresses the step.
- `done` rises with the final `tick` and holds until `start`/`load`/reset.
- Reset asserted mid-period clears everything immediately (async). No partial-count carry-over.

## Structure
- Shared package `seq_pkg`:
  - `mode_t` enum (`MODE_UP`, `MODE_DOWN`, `MODE_PINGPONG`, `MODE_ONESHOT`).
  - `DIR_UP`/`DIR_DOWN` constants.
- Sub-module `tick_prescaler #(DIV)`, with ports `clk`, `rst_n`, `en`, `clr` and output `ce`. It replaces the previous derived-clock divider; there is no generated clock anywhere in the design.
- `state_sequencer` holds the state, direction and done registers plus the output pulse registers.

## Test plan
- Reset/free-run, defaults (N=4, DIV=100), `en=1`, mode 0: state 0→1→2→3→0, with a step every 100 cycles. `wrap` pulses once on the 3→0 step; `tick` pulses 4 times in 400 cycles.
- Ping-pong, N=5, DIV=1, mode 2: state reads 0,1,2,3,4,3,2,1,0,1. `wrap` pulses on the steps landing on 4 and on 0.
- One-shot, N=4, DIV=3, mode 3: reaches 3 after 9 cycles with `done=1`. It stays at 3 with no `tick` for 30 cycles. `start` then gives state=0 and `done=0` next cycle, and stepping resumes 3 cycles later.
- Load/priority, DIV=2: `load=1`, `load_val=7` with N=6 gives state=5 (clamped). `load` and `start` in the same cycle as `step_ce` with `load_val=2` give state=2, no `tick`, and the next step occurs 2 cycles later.
- Enable gating, DIV=10: drop `en` after 6 counts for 20 cycles, then re-raise it. The step occurs exactly 4 enabled cycles after re-raise, and `state` is unchanged while `en=0`.
- Async reset, mode 2, going down at state 2: assert `rst_n=0` between edges. `state`, `tick`, `wrap` and `done` go to 0 immediately. After release, the first step goes 0→1 (direction up).
